// File: rtl/eth_arp_tx_pkg.sv
// Shared constants and types for the Ethernet ARP transmit path.
package eth_arp_tx_pkg;

  localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
  localparam int unsigned ARP_FRAME_WORDS = 15;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } arp_state_e;

endpackage

// File: rtl/eth_arp_word_mux.sv
// Combinational word selector for an ARP reply frame; reusable by other TX builders.
module eth_arp_word_mux
  import eth_arp_tx_pkg::*;
(
  input  logic [3:0]  word_idx,
  input  logic [47:0] self_mac,
  input  logic [31:0] self_ip,
  input  logic [47:0] req_mac,
  input  logic [31:0] req_ip,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (word_idx)
      4'd0:    word = req_mac[47:16];
      4'd1:    word = {req_mac[15:0], self_mac[47:32]};
      4'd2:    word = self_mac[31:0];
      4'd3:    word = {ETH_TYPE_ARP, ARP_HTYPE_ETH};
      4'd4:    word = {ETH_TYPE_IPV4, 8'h06, 8'h04};
      4'd5:    word = {ARP_OPER_REPLY, self_mac[47:32]};
      4'd6:    word = self_mac[31:0];
      4'd7:    word = self_ip;
      4'd8:    word = req_mac[47:16];
      4'd9:    word = {req_mac[15:0], req_ip[31:16]};
      4'd10:   word = {req_ip[15:0], 16'h0000};
      // W11..W14 are zero padding up to the 60-byte minimum frame.
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/eth_arp_tx.sv
// ARP reply frame generator: latches addresses on i_sync and streams a fixed
// 60-byte reply as 32-bit words with valid/ready handshake.
module eth_arp_tx
  import eth_arp_tx_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = ARP_FRAME_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sync,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [47:0] i_req_mac,
  input  logic [31:0] i_req_ip,
  output logic [31:0] o_out_data,
  output logic        o_out_sop,
  output logic        o_out_eop,
  output logic        o_out_vld,
  output logic [1:0]  o_out_empty,
  input  logic        i_out_rdy,
  output logic        o_ready
);

  localparam logic [3:0] LastIdx = 4'(FRAME_WORDS - 1);

  arp_state_e  state_q;
  logic [3:0]  word_idx_q;
  logic [47:0] self_mac_q;
  logic [31:0] self_ip_q;
  logic [47:0] req_mac_q;
  logic [31:0] req_ip_q;
  logic [31:0] mux_word;
  logic        send;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      self_mac_q <= '0;
      self_ip_q  <= '0;
      req_mac_q  <= '0;
      req_ip_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_sync) begin
            self_mac_q <= i_self_mac;
            self_ip_q  <= i_self_ip;
            req_mac_q  <= i_req_mac;
            req_ip_q   <= i_req_ip;
            word_idx_q <= '0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          // i_sync is deliberately ignored here so the frame in flight stays intact.
          if (i_out_rdy) begin
            if (word_idx_q == LastIdx) begin
              word_idx_q <= '0;
              state_q    <= StIdle;
            end else begin
              word_idx_q <= word_idx_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  eth_arp_word_mux u_word_mux (
    .word_idx (word_idx_q),
    .self_mac (self_mac_q),
    .self_ip  (self_ip_q),
    .req_mac  (req_mac_q),
    .req_ip   (req_ip_q),
    .word     (mux_word)
  );

  // All outputs come straight from registers, never from i_out_rdy.
  assign send        = (state_q == StSend);
  assign o_out_vld   = send;
  assign o_ready     = ~send;
  assign o_out_sop   = send && (word_idx_q == 4'd0);
  assign o_out_eop   = send && (word_idx_q == LastIdx);
  assign o_out_data  = send ? mux_word : 32'h0;
  assign o_out_empty = 2'b00;

endmodule

// File: tb/tb_eth_arp_tx.sv
// Scoreboard bench for eth_arp_tx: expected words are queued at frame start and
// popped by a monitor on every accepted word.
module tb_eth_arp_tx;

  logic        clk;
  logic        rst_n;
  logic        i_sync;
  logic [47:0] i_self_mac;
  logic [31:0] i_self_ip;
  logic [47:0] i_req_mac;
  logic [31:0] i_req_ip;
  logic [31:0] o_out_data;
  logic        o_out_sop;
  logic        o_out_eop;
  logic        o_out_vld;
  logic [1:0]  o_out_empty;
  logic        i_out_rdy;
  logic        o_ready;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  eth_arp_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sync      (i_sync),
    .i_self_mac  (i_self_mac),
    .i_self_ip   (i_self_ip),
    .i_req_mac   (i_req_mac),
    .i_req_ip    (i_req_ip),
    .o_out_data  (o_out_data),
    .o_out_sop   (o_out_sop),
    .o_out_eop   (o_out_eop),
    .o_out_vld   (o_out_vld),
    .o_out_empty (o_out_empty),
    .i_out_rdy   (i_out_rdy),
    .o_ready     (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(int i, logic [47:0] sm, logic [31:0] si,
                                           logic [47:0] rm, logic [31:0] ri);
    case (i)
      0:  return rm[47:16];
      1:  return {rm[15:0], sm[47:32]};
      2:  return sm[31:0];
      3:  return 32'h0806_0001;
      4:  return 32'h0800_0604;
      5:  return {16'h0002, sm[47:32]};
      6:  return sm[31:0];
      7:  return si;
      8:  return rm[47:16];
      9:  return {rm[15:0], ri[31:16]};
      10: return {ri[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every accepted word is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && o_out_vld && i_out_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, required no word",
                 o_out_data, o_out_sop, o_out_eop);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_out_data !== e.data || o_out_sop !== e.sop || o_out_eop !== e.eop
            || o_out_empty !== 2'b00) begin
          errors++;
          $display("FAIL word: got data=%h sop=%b eop=%b empty=%0d, required %h sop=%b eop=%b empty=0",
                   o_out_data, o_out_sop, o_out_eop, o_out_empty, e.data, e.sop, e.eop);
        end
      end
    end
  end

  task automatic push_frame();
    for (int i = 0; i < 15; i++) begin
      exp_t e;
      e.data = exp_word(i, i_self_mac, i_self_ip, i_req_mac, i_req_ip);
      e.sop  = (i == 0);
      e.eop  = (i == 14);
      sb.push_back(e);
    end
  endtask

  // Leaves time at #1 after the edge that captured i_sync, i.e. in the W0 cycle.
  task automatic start_frame();
    push_frame();
    @(posedge clk); #1;
    i_sync = 1'b1;
    @(posedge clk); #1;
    i_sync = 1'b0;
  endtask

  task automatic check_sb_empty(string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: got %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (o_out_vld !== 1'b0 || o_out_sop !== 1'b0 || o_out_eop !== 1'b0 || o_ready !== 1'b1
        || o_out_data !== 32'h0 || o_out_empty !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b sop=%b eop=%b rdy=%b data=%h empty=%0d, required 0 0 0 1 0 0",
               o_out_vld, o_out_sop, o_out_eop, o_ready, o_out_data, o_out_empty);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int low = 0;
    bit vld_ok = 1'b1;
    i_out_rdy = 1'b1;
    start_frame();
    checks++;
    if (o_out_vld !== 1'b1 || o_out_sop !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: got vld=%b sop=%b rdy=%b, required 1 1 0",
               o_out_vld, o_out_sop, o_ready);
    end
    for (int g = 0; g < 100 && o_ready !== 1'b1; g++) begin
      low++;
      if (o_out_vld !== 1'b1) vld_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (low != 15 || !vld_ok) begin
      errors++;
      $display("FAIL basic_frame_len: got %0d busy cycles (vld steady=%b), required 15 (1)",
               low, vld_ok);
    end
    checks++;
    if (o_out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_vld: got %b, required 0", o_out_vld);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_backpressure();
    int low = 0, stalls = 0, k = 0, bad_hold = 0;
    logic [33:0] held;
    bit stalled;
    start_frame();
    for (int g = 0; g < 200 && o_ready !== 1'b1; g++) begin
      low++;
      i_out_rdy = (k % 3 == 0);
      stalled   = !i_out_rdy;
      if (stalled) stalls++;
      held = {o_out_data, o_out_sop, o_out_eop};
      k++;
      @(posedge clk); #1;
      if (stalled && held !== {o_out_data, o_out_sop, o_out_eop}) bad_hold++;
    end
    i_out_rdy = 1'b1;
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable stall cycles, required 0", bad_hold);
    end
    checks++;
    if (low != 15 + stalls) begin
      errors++;
      $display("FAIL stall_frame_len: got %0d cycles, required %0d", low, 15 + stalls);
    end
    check_sb_empty("stall");
  endtask

  task automatic test_ignored_inputs();
    int low = 0, rises = 0, vld_seen = 0;
    logic [31:0] orig_ip = i_req_ip;
    logic prev;
    i_out_rdy = 1'b1;
    start_frame();
    for (int g = 0; g < 100 && o_ready !== 1'b1; g++) begin
      // low counts words already transferred, so the visible word is W<low>.
      i_sync = (low == 5 || low == 14);
      if (low == 3) i_req_ip = 32'h0A0B_0C0D;
      low++;
      @(posedge clk); #1;
    end
    i_sync = 1'b0;
    prev = o_ready;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_out_vld) vld_seen++;
      if (o_ready && !prev) rises++;
      prev = o_ready;
    end
    checks++;
    if (low != 15 || vld_seen != 0 || rises != 0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_sync: got len=%0d extra_vld=%0d extra_rises=%0d rdy=%b, required 15 0 0 1",
               low, vld_seen, rises, o_ready);
    end
    check_sb_empty("ignored");
    i_req_ip = orig_ip;
  endtask

  task automatic test_reset_mid();
    int low = 0;
    i_out_rdy = 1'b1;
    start_frame();
    for (int g = 0; g < 7; g++) begin
      low++;
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_out_vld !== 1'b0 || o_ready !== 1'b1 || o_out_data !== 32'h0 || o_out_sop !== 1'b0
        || o_out_eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b rdy=%b data=%h sop=%b eop=%b, required 0 1 0 0 0",
               o_out_vld, o_ready, o_out_data, o_out_sop, o_out_eop);
    end
    checks++;
    if (sb.size() != 8) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d words left, required 8", sb.size());
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_out_vld !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_resume: got vld=%b rdy=%b, required 0 1", o_out_vld, o_ready);
    end
    i_self_mac = 48'h0211_2233_4455;
    i_req_ip   = 32'h0A00_0063;
    test_basic();
  endtask

  task automatic test_back_to_back();
    int high = 0;
    bit fired = 1'b0;
    i_out_rdy = 1'b1;
    start_frame();
    push_frame();
    for (int g = 0; g < 100 && !fired; g++) begin
      if (o_ready === 1'b1) begin
        high++;
        i_sync = 1'b1;
        fired  = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_sync = 1'b0;
    checks++;
    if (!fired || o_out_vld !== 1'b1 || o_out_sop !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: got fired=%b vld=%b sop=%b rdy=%b, required 1 1 1 0",
               fired, o_out_vld, o_out_sop, o_ready);
    end
    checks++;
    if (high != 1) begin
      errors++;
      $display("FAIL b2b_ready_high: got %0d high cycles, required 1", high);
    end
    for (int g = 0; g < 100 && o_ready !== 1'b1; g++) begin
      @(posedge clk); #1;
    end
    check_sb_empty("b2b");
  endtask

  initial begin
    i_sync     = 1'b0;
    i_out_rdy  = 1'b1;
    i_self_mac = 48'h0200_0000_0001;
    i_self_ip  = 32'hC0A8_0001;
    i_req_mac  = 48'hAABB_CCDD_EEFF;
    i_req_ip   = 32'hC0A8_0002;
    rst_n      = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/eth_arp_tx.md
# eth_arp_tx

ARP reply generator on the transmit side of the packet-type arbiter. It takes the `o_arp_sync` start pulse and the latched requester MAC/IP from the arbiter, and builds a 60-byte Ethernet ARP reply frame. The frame is streamed as 32-bit words toward the MAC TX FIFO. `o_ready` is the arbiter's `i_arp_ready`: it falls while a frame is in flight, and its rising edge releases the arbiter back to PT_NONE.

## Interface
Parameters:
- `FRAME_WORDS`, default 15: 32-bit words per frame (60 bytes, minimum Ethernet payload+header, no FCS).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `i_sync`  in  1  one-cycle start pulse (arbiter `o_arp_sync`)
- `i_self_mac`  in  48  own MAC
- `i_self_ip`  in  32  own IP
- `i_req_mac`  in  48  requester MAC (arbiter `o_arp_req_mac`)
- `i_req_ip`  in  32  requester IP (arbiter `o_arp_req_ip`)
- `o_out_data`  out  32  stream data, first byte in [31:24]
- `o_out_sop`  out  1  first word of frame
- `o_out_eop`  out  1  last word of frame
- `o_out_vld`  out  1  word valid
- `o_out_empty`  out  2  empty bytes in eop word, constant 0
- `i_out_rdy`  in  1  sink accepts word
- `o_ready`  out  1  idle/finished; rising edge ends arbiter ARP state

## Operation
- States: IDLE, SEND.
- **IDLE**
  - `o_ready`=1, `o_out_vld`=0.
  - On `i_sync`=1, latch all four address inputs, clear `word_idx` (4 bit), go to SEND.
- **SEND**
  - `o_ready`=0, `o_out_vld`=1.
  - `o_out_data` is the word selected by `word_idx`, built from the latched values only.
  - A word transfers when `o_out_vld`&&`i_out_rdy`; then `word_idx` increments.
  - On transfer of word FRAME_WORDS-1, return to IDLE.
- **Word map:**
  - W0 `req_mac[47:16]`
  - W1 `{req_mac[15:0],self_mac[47:32]}`
  - W2 `self_mac[31:0]`
  - W3 `{16'h0806,16'h0001}`
  - W4 `{16'h0800,8'h06,8'h04}`
  - W5 `{16'h0002,self_mac[47:32]}`
  - W6 `self_mac[31:0]`
  - W7 `self_ip`
  - W8 `req_mac[47:16]`
  - W9 `{req_mac[15:0],req_ip[31:16]}`
  - W10 `{req_ip[15:0],16'h0000}`
  - W11–W14 zero padding
- `o_out_sop` = SEND && `word_idx`==0.
- `o_out_eop` = SEND && `word_idx`==FRAME_WORDS-1.
- **Back-pressure:** while `i_out_rdy`=0, data, sop and eop hold stable and `word_idx` does not advance.
- **`i_sync` while in SEND:** ignored; latched addresses are not disturbed. This includes a pulse in the same cycle as the eop transfer.
- **Input changes after start:** changes on `i_req_*`/`i_self_*` during SEND do not affect the frame in flight.
- **Reset** (any time, including mid-frame):
  - state=IDLE, `word_idx`=0, latches=0.
  - `o_out_vld`=0, `o_out_sop`=0, `o_out_eop`=0, `o_out_data`=0, `o_out_empty`=0, `o_ready`=1.
  - A truncated frame is not resumed.

## Timing
- **Start:** `i_sync` at edge N makes SEND visible after edge N: `o_ready` low and `o_out_vld`/`o_out_sop` with W0 in cycle N+1 (one-cycle latency).
- **Throughput:** with `i_out_rdy` held 1, W0..W14 occupy cycles N+1..N+15, one per cycle.
- **End:** the eop transfer at the end of cycle N+15 gives `o_out_vld`=0 and `o_ready`=1 in cycle N+16. That is a single 0→1 edge per frame.
- **Back-to-back:** the earliest next frame is `i_sync` in cycle N+16, with W0 appearing in cycle N+17.
- **Stalls:** each cycle with `i_out_rdy`=0 during SEND adds exactly one cycle to the frame.
- `o_ready` is registered (derived from state), never combinational from `i_out_rdy`.

## Structure
- **Shared package:** `ETH_TYPE_ARP`=16'h0806, `ETH_TYPE_IPV4`=16'h0800, `ARP_HTYPE_ETH`=16'h0001, `ARP_OPER_REPLY`=16'h0002, `ARP_FRAME_WORDS`=15.
  - `ARP_FRAME_WORDS` is the default for `FRAME_WORDS`.
- **Sub-module `eth_arp_word_mux`:** purely combinational. It maps `word_idx` plus latched addresses to `o_out_data` and is reused by later TX builders.
- The FSM, counter and latches stay in `eth_arp_tx`.

## Test plan
1. **Basic frame, no stalls.** Reset, then `i_sync` with self_mac=02:00:00:00:00:01, self_ip=C0A80001, req_mac=AA:BB:CC:DD:EE:FF, req_ip=C0A80002, `i_out_rdy`=1.
   - W0=AABBCCDD, W1=EEFF0200, W3=08060001, W5=00020200, W7=C0A80001, W9=EEFFC0A8, W10=00020000, W11..W14=0.
   - sop on W0 only, eop on W14 only, 15 consecutive valid cycles, `o_ready` low for exactly 15 cycles.
2. **Back-pressure.** Same frame with `i_out_rdy` toggled 1,0,0,1,…
   - Data and sop/eop stable while stalled.
   - Completes in 15 + number of stall cycles.
   - Word sequence identical to scenario 1.
3. **Ignored inputs during SEND.** Pulse `i_sync` at W5 and on the eop cycle; change `i_req_ip` mid-frame.
   - Exactly one frame with the original addresses; no second frame.
   - `o_ready` rises once.
4. **Reset mid-frame.** Assert `rst_n`=0 during W7.
   - `o_out_vld`=0 and `o_ready`=1 immediately (asynchronous).
   - After release, the next `i_sync` yields a complete frame starting at W0.
5. **Back-to-back.** `i_sync` in the first cycle after `o_ready` rises.
   - Second frame's W0 valid one cycle later.
   - `o_ready` shows a 0→1→0 pattern with a single high cycle.
6. **Integration with the arbiter.** ARP request received, PT_NONE→PT_ARP.
   - `o_arp_sync` starts the frame.
   - The arbiter returns to PT_NONE one cycle after `o_ready` rises.
